// File: rtl/force_reduce_drain.sv
// Drains force packets from the upstream FIFO and merges consecutive same-id packets
// into one reduced record per run. Define REDUCE_SAT_EN for saturating sums plus sat_flag.
module force_reduce_drain #(
    parameter int unsigned ID_WIDTH  = 16,
    parameter int unsigned F_WIDTH   = 16,
    parameter int unsigned ACC_WIDTH = 24,
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned PKT_WIDTH = ID_WIDTH + 3 * F_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PKT_WIDTH-1:0] buf_out,
    input  logic                 buf_empty,
    output logic                 buf_consume,
    input  logic                 flush,
    output logic [ID_WIDTH-1:0]  out_id,
    output logic [ACC_WIDTH-1:0] out_fx,
    output logic [ACC_WIDTH-1:0] out_fy,
    output logic [ACC_WIDTH-1:0] out_fz,
    output logic [CNT_WIDTH-1:0] out_cnt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 flush_done
`ifdef REDUCE_SAT_EN
    ,
    output logic                 sat_flag
`endif
);

    typedef enum logic {S_IDLE, S_ACCUM} state_e;

    state_e                 state_q, state_d;
    logic [ID_WIDTH-1:0]    id_q, id_d;
    logic [ACC_WIDTH-1:0]   ax_q, ax_d, ay_q, ay_d, az_q, az_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   rd_vld_q;
    logic                   hold_vld_q, hold_vld_d;
    logic [PKT_WIDTH-1:0]   hold_pkt_q, hold_pkt_d;
    logic                   oval_q, oval_d;
    logic [ID_WIDTH-1:0]    oid_q, oid_d;
    logic [ACC_WIDTH-1:0]   ox_q, ox_d, oy_q, oy_d, oz_q, oz_d;
    logic [CNT_WIDTH-1:0]   ocnt_q, ocnt_d;
    logic                   fpend_q, fpend_d;
    logic                   fdone_q, fdone_d;

    logic                   stall, slot_free, pkt_vld;
    logic [PKT_WIDTH-1:0]   pkt;
    logic [ID_WIDTH-1:0]    p_id;
    logic [F_WIDTH-1:0]     p_fx, p_fy, p_fz;
    logic [ACC_WIDTH-1:0]   sum_x, sum_y, sum_z;

    function automatic logic [ACC_WIDTH-1:0] sext(input logic [F_WIDTH-1:0] v);
        return ACC_WIDTH'($signed(v));
    endfunction

    function automatic logic ovf(input logic [ACC_WIDTH-1:0] a, input logic [F_WIDTH-1:0] b);
        logic [ACC_WIDTH-1:0] be, s;
        be = sext(b);
        s  = a + be;
        return (a[ACC_WIDTH-1] == be[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
    endfunction

    function automatic logic [ACC_WIDTH-1:0] add_comp(input logic [ACC_WIDTH-1:0] a,
                                                      input logic [F_WIDTH-1:0]   b);
        logic [ACC_WIDTH-1:0] s;
        s = a + sext(b);
`ifdef REDUCE_SAT_EN
        if (ovf(a, b))
            s = a[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`endif
        return s;
    endfunction

    assign stall       = oval_q & ~out_ready;
    assign slot_free   = ~stall;
    assign buf_consume = rst & ~buf_empty & ~hold_vld_q & ~stall & ~fpend_q;

    // A held packet always takes priority: the consume rule keeps rd_vld low while it waits.
    assign pkt_vld = hold_vld_q | rd_vld_q;
    assign pkt     = hold_vld_q ? hold_pkt_q : buf_out;
    assign p_id    = pkt[PKT_WIDTH-1 -: ID_WIDTH];
    assign p_fx    = pkt[3*F_WIDTH-1 -: F_WIDTH];
    assign p_fy    = pkt[2*F_WIDTH-1 -: F_WIDTH];
    assign p_fz    = pkt[F_WIDTH-1:0];
    assign sum_x   = add_comp(ax_q, p_fx);
    assign sum_y   = add_comp(ay_q, p_fy);
    assign sum_z   = add_comp(az_q, p_fz);

`ifdef REDUCE_SAT_EN
    logic sat_q, sat_d, sat_hit;
    assign sat_hit  = ovf(ax_q, p_fx) | ovf(ay_q, p_fy) | ovf(az_q, p_fz);
    assign sat_flag = sat_q;
`endif

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        ax_d       = ax_q;
        ay_d       = ay_q;
        az_d       = az_q;
        cnt_d      = cnt_q;
        hold_vld_d = hold_vld_q;
        hold_pkt_d = hold_pkt_q;
        oval_d     = oval_q & ~out_ready;
        oid_d      = oid_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        oz_d       = oz_q;
        ocnt_d     = ocnt_q;
        fpend_d    = fpend_q;
        fdone_d    = 1'b0;
`ifdef REDUCE_SAT_EN
        sat_d      = sat_q;
`endif
        if (pkt_vld) begin
            if (state_q == S_ACCUM && p_id == id_q && cnt_q != '1) begin
                ax_d  = sum_x;
                ay_d  = sum_y;
                az_d  = sum_z;
                cnt_d = cnt_q + CNT_WIDTH'(1);
`ifdef REDUCE_SAT_EN
                sat_d = sat_q | sat_hit;
`endif
            end else if (state_q == S_IDLE || slot_free) begin
                if (state_q == S_ACCUM) begin
                    oval_d = 1'b1;
                    oid_d  = id_q;
                    ox_d   = ax_q;
                    oy_d   = ay_q;
                    oz_d   = az_q;
                    ocnt_d = cnt_q;
                end
                state_d    = S_ACCUM;
                id_d       = p_id;
                ax_d       = sext(p_fx);
                ay_d       = sext(p_fy);
                az_d       = sext(p_fz);
                cnt_d      = CNT_WIDTH'(1);
                hold_vld_d = 1'b0;
            end else begin
                hold_vld_d = 1'b1;
                hold_pkt_d = pkt;
            end
        end else if (fpend_q && (state_q == S_IDLE || slot_free)) begin
            if (state_q == S_ACCUM) begin
                oval_d = 1'b1;
                oid_d  = id_q;
                ox_d   = ax_q;
                oy_d   = ay_q;
                oz_d   = az_q;
                ocnt_d = cnt_q;
            end
            state_d = S_IDLE;
            fdone_d = 1'b1;
            fpend_d = 1'b0;
        end
        if (flush && !fpend_q)
            fpend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            id_q       <= '0;
            ax_q       <= '0;
            ay_q       <= '0;
            az_q       <= '0;
            cnt_q      <= '0;
            rd_vld_q   <= 1'b0;
            hold_vld_q <= 1'b0;
            hold_pkt_q <= '0;
            oval_q     <= 1'b0;
            oid_q      <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            oz_q       <= '0;
            ocnt_q     <= '0;
            fpend_q    <= 1'b0;
            fdone_q    <= 1'b0;
`ifdef REDUCE_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            ax_q       <= ax_d;
            ay_q       <= ay_d;
            az_q       <= az_d;
            cnt_q      <= cnt_d;
            rd_vld_q   <= buf_consume;
            hold_vld_q <= hold_vld_d;
            hold_pkt_q <= hold_pkt_d;
            oval_q     <= oval_d;
            oid_q      <= oid_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            oz_q       <= oz_d;
            ocnt_q     <= ocnt_d;
            fpend_q    <= fpend_d;
            fdone_q    <= fdone_d;
`ifdef REDUCE_SAT_EN
            sat_q      <= sat_d;
`endif
        end
    end

    assign out_valid  = oval_q;
    assign out_id     = oid_q;
    assign out_fx     = ox_q;
    assign out_fy     = oy_q;
    assign out_fz     = oz_q;
    assign out_cnt    = ocnt_q;
    assign flush_done = fdone_q;
    assign busy       = (state_q == S_ACCUM) | rd_vld_q | hold_vld_q | oval_q;

endmodule

// File: tb/tb_force_reduce_drain.sv
// Scoreboard bench for force_reduce_drain with a 1-cycle-latency FIFO model upstream.
// Built with small ACC/CNT widths so wrap and counter-limit cases are reachable.
module tb_force_reduce_drain;

    localparam int unsigned IDW = 16, FW = 16, ACCW = 16, CNTW = 2;
    localparam int unsigned PKW = IDW + 3 * FW;

    typedef logic [IDW+3*ACCW+CNTW-1:0] rec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [PKW-1:0]  buf_out;
    logic            buf_empty;
    logic            buf_consume;
    logic            flush;
    logic [IDW-1:0]  out_id;
    logic [ACCW-1:0] out_fx, out_fy, out_fz;
    logic [CNTW-1:0] out_cnt;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic            flush_done;
`ifdef REDUCE_SAT_EN
    logic            sat_flag;
`endif

    force_reduce_drain #(
        .ID_WIDTH (IDW),
        .F_WIDTH  (FW),
        .ACC_WIDTH(ACCW),
        .CNT_WIDTH(CNTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .buf_out    (buf_out),
        .buf_empty  (buf_empty),
        .buf_consume(buf_consume),
        .flush      (flush),
        .out_id     (out_id),
        .out_fx     (out_fx),
        .out_fy     (out_fy),
        .out_fz     (out_fz),
        .out_cnt    (out_cnt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .flush_done (flush_done)
`ifdef REDUCE_SAT_EN
        ,
        .sat_flag   (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // FIFO model: registered read data, zeros when not popping
    logic [PKW-1:0] mem [0:255];
    int             wr_ptr = 0;
    int             rd_ptr = 0;
    int             ecnt   = 0;
    assign buf_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        ecnt <= ecnt + 1;
        if (buf_consume && !buf_empty) begin
            buf_out <= mem[rd_ptr[7:0]];
            rd_ptr  <= rd_ptr + 1;
        end else begin
            buf_out <= '0;
        end
    end

    rec_t sb[$];

    task automatic push_pkt(input int id, input int fx, input int fy, input int fz);
        mem[wr_ptr[7:0]] = {16'(id), 16'(fx), 16'(fy), 16'(fz)};
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_rec(input int id, input int fx, input int fy, input int fz, input int cnt);
        sb.push_back({16'(id), 16'(fx), 16'(fy), 16'(fz), 2'(cnt)});
    endtask

    // Monitor: handshake scoreboard, stall stability, flush_done bookkeeping
    int   fd_cnt = 0;
    logic fd_valid = 1'b0;
    int   pop7_edge = -1;
    logic prev_stall = 1'b0;
    rec_t prev_rec;

    initial begin
        rec_t cur, e;
        forever begin
            @(negedge clk);
            #1;
            if (rst === 1'b1) begin
                cur = {out_id, out_fx, out_fy, out_fz, out_cnt};
                check_eq("consume_when_empty", 96'(buf_consume & buf_empty), 96'(0));
                if (pop7_edge < 0 && buf_consume && !buf_empty && mem[rd_ptr[7:0]][63:48] == 16'd7)
                    pop7_edge = ecnt;
                if (prev_stall)
                    check_eq("stall_hold", 96'({out_valid, cur}), 96'({1'b1, prev_rec}));
                if (out_valid && out_ready) begin
                    check_eq("rec_pending", 96'(sb.size() > 0), 96'(1));
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check_eq("record", 96'(cur), 96'(e));
                    end
                end
                if (flush_done) begin
                    fd_cnt   = fd_cnt + 1;
                    fd_valid = out_valid;
                end
                prev_stall = out_valid & ~out_ready;
                prev_rec   = cur;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic do_flush(input logic expect_emit);
        int fd0;
        int k;
        k = 0;
        while (rd_ptr != wr_ptr && k < 300) begin
            @(negedge clk);
            k++;
        end
        check_eq("fifo_drained", 96'(rd_ptr == wr_ptr), 96'(1));
        repeat (3) @(negedge clk);
        fd0   = fd_cnt;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        k = 0;
        while (fd_cnt == fd0 && k < 50) begin
            @(negedge clk);
            #2;
            k++;
        end
        repeat (3) @(negedge clk);
        check_eq("flush_done_pulses", 96'(fd_cnt - fd0), 96'(1));
        if (expect_emit)
            check_eq("flush_emit_same_cycle", 96'(fd_valid), 96'(1));
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((sb.size() != 0 || busy) && k < 200) begin
            @(negedge clk);
            #2;
            k++;
        end
        check_eq(tag, 96'({sb.size() == 0, busy}), 96'({1'b1, 1'b0}));
    endtask

    task automatic run_random();
        int   cur_id, cnt, id, fx, fy, fz;
        logic [15:0] sx, sy, sz;
        int   k;
        cur_id = -1;
        cnt    = 0;
        sx = '0; sy = '0; sz = '0;
        for (int i = 0; i < 40; i++) begin
            id = int'($urandom_range(1, 2));
            fx = int'($urandom_range(0, 200)) - 100;
            fy = int'($urandom_range(0, 200)) - 100;
            fz = int'($urandom_range(0, 200)) - 100;
            push_pkt(id, fx, fy, fz);
            if (cnt > 0 && id == cur_id && cnt < 3) begin
                sx = sx + 16'(fx);
                sy = sy + 16'(fy);
                sz = sz + 16'(fz);
                cnt++;
            end else begin
                if (cnt > 0) expect_rec(cur_id, int'(sx), int'(sy), int'(sz), cnt);
                cur_id = id;
                sx = 16'(fx); sy = 16'(fy); sz = 16'(fz);
                cnt = 1;
            end
        end
        expect_rec(cur_id, int'(sx), int'(sy), int'(sz), cnt);
        k = 0;
        while (rd_ptr != wr_ptr && k < 400) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            k++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        do_flush(1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 96'(out_valid), 96'(0));
        check_eq("rst_busy", 96'(busy), 96'(0));
        check_eq("rst_consume", 96'(buf_consume), 96'(0));
        check_eq("rst_flush_done", 96'(flush_done), 96'(0));
        check_eq("rst_record", 96'({out_id, out_fx, out_fy, out_fz, out_cnt}), 96'(0));
        rst = 1'b1;

        // Empty FIFO, then a flush with nothing open
        repeat (20) @(negedge clk);
        check_eq("idle_consume", 96'(buf_consume), 96'(0));
        check_eq("idle_out_valid", 96'(out_valid), 96'(0));
        check_eq("idle_busy", 96'(busy), 96'(0));
        do_flush(1'b0);

        // Run merge and output latency
        push_pkt(5, 1, 2, 3);
        push_pkt(5, 10, 20, -30);
        push_pkt(7, 4, 4, 4);
        expect_rec(5, 11, 22, -27, 2);
        expect_rec(7, 4, 4, 4, 1);
        k = 0;
        do begin
            @(negedge clk);
            #2;
            k++;
        end while (!out_valid && k < 30);
        check_eq("close_latency", 96'(ecnt - pop7_edge), 96'(2));
        do_flush(1'b1);
        drain("drain_merge");

        // Backpressure with hold register occupied
        out_ready = 1'b0;
        push_pkt(1, 1, 1, 1);
        push_pkt(2, 2, 2, 2);
        push_pkt(3, 3, 3, 3);
        push_pkt(3, 3, 3, 3);
        expect_rec(1, 1, 1, 1, 1);
        expect_rec(2, 2, 2, 2, 1);
        expect_rec(3, 6, 6, 6, 2);
        repeat (10) @(negedge clk);
        #2;
        check_eq("bp_valid_id", 96'({out_valid, out_id}), 96'({1'b1, 16'd1}));
        check_eq("bp_consume", 96'(buf_consume), 96'(0));
        check_eq("bp_fifo_left", 96'(wr_ptr - rd_ptr), 96'(1));
        check_eq("bp_busy", 96'(busy), 96'(1));
        @(negedge clk);
        out_ready = 1'b1;
        do_flush(1'b1);
        drain("drain_bp");

        // Counter limit (max 3 per record)
        for (int i = 0; i < 5; i++) push_pkt(9, 1, 0, 0);
        expect_rec(9, 3, 0, 0, 3);
        expect_rec(9, 2, 0, 0, 2);
        do_flush(1'b1);
        drain("drain_cnt");

        // Component overflow
        push_pkt(4, 'h7FFF, 0, 0);
        push_pkt(4, 'h7FFF, 0, 0);
`ifdef REDUCE_SAT_EN
        expect_rec(4, 'h7FFF, 0, 0, 2);
`else
        expect_rec(4, 'hFFFE, 0, 0, 2);
`endif
        do_flush(1'b1);
        drain("drain_ovf");
`ifdef REDUCE_SAT_EN
        check_eq("sat_flag_set", 96'(sat_flag), 96'(1));
`endif

        run_random();
        drain("drain_random");

        // Asynchronous reset with an open accumulation
        push_pkt(11, 1, 1, 1);
        push_pkt(11, 1, 1, 1);
        repeat (6) @(negedge clk);
        check_eq("pre_rst_busy", 96'(busy), 96'(1));
        #3;
        rst = 1'b0;
        #1;
        check_eq("async_rst_busy", 96'(busy), 96'(0));
        check_eq("async_rst_valid", 96'(out_valid), 96'(0));
        check_eq("async_rst_consume", 96'(buf_consume), 96'(0));
`ifdef REDUCE_SAT_EN
        check_eq("async_rst_sat", 96'(sat_flag), 96'(0));
`endif
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("post_rst_quiet", 96'({out_valid, busy}), 96'(0));
        push_pkt(12, 5, 6, 7);
        expect_rec(12, 5, 6, 7, 1);
        do_flush(1'b1);
        drain("drain_post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
